// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and types.
// Used by the scanout reader and the writer side.
package fb_pkg;

  localparam int FB_DATA_W = 4;
  localparam int H_RES_DEF = 1280;
  localparam int V_RES_DEF = 720;

  localparam logic [7:0] GRAY_STEP = 8'd17;
  localparam logic [7:0] HEAT_STEP = 8'd34;

  typedef enum logic [1:0] {
    MODE_GRAY = 2'd0,
    MODE_INV  = 2'd1,
    MODE_HEAT = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

endpackage

// File: rtl/fb_palette_lut.sv
// Registered 4-bit code to 24-bit RGB palette.
// Invalid pixels register as black.
module fb_palette_lut
  import fb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [FB_DATA_W-1:0] code_i,
  input  logic [1:0]           mode_i,
  output logic [23:0]          rgb_o
);

  logic [7:0]  c8;
  logic [7:0]  r_d, g_d, b_d;
  logic [23:0] rgb_q;

  always_comb begin
    c8  = {4'b0, code_i};
    r_d = c8 * GRAY_STEP;
    g_d = r_d;
    b_d = r_d;
    unique case (mode_e'(mode_i))
      MODE_INV: begin
        r_d = 8'd255 - c8 * GRAY_STEP;
        g_d = r_d;
        b_d = r_d;
      end
      MODE_HEAT: begin
        r_d = code_i[3] ? 8'd255 : c8 * HEAT_STEP;
        g_d = code_i[3] ? (c8 - 8'd8) * HEAT_STEP : 8'd0;
        b_d = (code_i == 4'hF) ? 8'd255 : 8'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rgb_q <= '0;
    else      rgb_q <= valid_i ? {r_d, g_d, b_d} : 24'd0;
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/fb_scanout_reader.sv
// Display-side frame-buffer reader: timing coords to BRAM
// address, read-latency alignment, palette and sync delay.
module fb_scanout_reader
  import fb_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = 20,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          i_sx,
  input  logic [15:0]          i_sy,
  input  logic                 i_de,
  input  logic                 i_hsync,
  input  logic                 i_vsync,
  input  logic [1:0]           i_mode,
  output logic [ADDR_W-1:0]    o_addr,
  output logic                 o_en,
  input  logic [FB_DATA_W-1:0] i_data,
  output logic [7:0]           o_red,
  output logic [7:0]           o_green,
  output logic [7:0]           o_blue,
  output logic                 o_de,
  output logic                 o_hsync,
  output logic                 o_vsync,
  output logic                 o_err
);

  localparam int L = RD_LAT + 2;
  localparam logic [15:0] H_LIM = 16'(H_RES);
  localparam logic [15:0] V_LIM = 16'(V_RES);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_RES);

  logic [15:0]       row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              lost_q, lost_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;
  logic [1:0]        mode_q, mode_d;
  logic              vs_prev_q;
  logic [RD_LAT-1:0] vld_q;
  logic [3*L-1:0]    sync_q;
  logic [23:0]       rgb;

  // Row base advances by one stride per line, so no multiply.
  always_comb begin
    row_d  = row_q;
    base_d = base_q;
    lost_d = lost_q;
    err_d  = err_q;
    if (i_sy == 16'd0) begin
      row_d  = '0;
      base_d = '0;
      lost_d = 1'b0;
    end else if (i_sy == row_q + 16'd1) begin
      row_d  = row_q + 16'd1;
      base_d = base_q + STRIDE;
    end else if (i_sy != row_q) begin
      lost_d = 1'b1;
      err_d  = 1'b1;
    end
  end

  always_comb begin
    en_d = i_de & (i_sx < H_LIM) & (i_sy < V_LIM) & ~lost_q;
    addr_d = en_d ? base_q + ADDR_W'(i_sx) : addr_q;
    mode_d = (i_vsync & ~vs_prev_q) ? i_mode : mode_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q     <= '0;
      base_q    <= '0;
      lost_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      en_q      <= 1'b0;
      mode_q    <= '0;
      vs_prev_q <= 1'b0;
      vld_q     <= '0;
      sync_q    <= '0;
    end else begin
      row_q     <= row_d;
      base_q    <= base_d;
      lost_q    <= lost_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      vs_prev_q <= i_vsync;
      vld_q     <= RD_LAT'({vld_q, en_q});
      sync_q    <= (3*L)'({sync_q, i_de, i_hsync, i_vsync});
    end
  end

  fb_palette_lut u_lut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (vld_q[RD_LAT-1]),
    .code_i  (i_data),
    .mode_i  (mode_q),
    .rgb_o   (rgb)
  );

  assign o_addr = addr_q;
  assign o_en   = en_q;
  assign o_err  = err_q;
  assign {o_red, o_green, o_blue} = rgb;
  assign {o_de, o_hsync, o_vsync} = sync_q[3*L-1 -: 3];

endmodule
